// File: rtl/sa_pkg.sv
// sa_pkg: constants and types shared by the systolic array and its activation feeder.
package sa_pkg;

    localparam int SA_ARRAY_N        = 4;
    localparam int SA_ACT_WIDTH      = 16;
    // Sideband bits carried with each lane beat: {last, valid}
    localparam int SA_LANE_TAG_WIDTH = 2;

    typedef enum logic [1:0] {
        FEED_IDLE  = 2'd0,
        FEED_ISSUE = 2'd1,
        FEED_DRAIN = 2'd2,
        FEED_DONE  = 2'd3
    } feed_state_t;

    // LSB of lane n inside a packed ARRAY_N*ACT_WIDTH activation word
    function automatic int lane_lsb(input int lane, input int act_width);
        return lane * act_width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: enable-gated shift register of DEPTH stages; DEPTH=0 is a wire.
// Used once per activation lane to carry {last, valid, data} with the diagonal skew.
module skew_delay_line #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, reset, en};
            assign dout       = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Advance one stage per enabled cycle; a low enable freezes every stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ibuf_skew_feeder.sv
// ibuf_skew_feeder: walks the IBUF row by row, issues reads, skews lane n by n cycles
// and drives per-lane data/valid/last into the systolic array, with array_ready
// backpressure freezing the whole feeder.
// Build option: FEEDER_ZERO_FILL_EN -- invalid lanes drive zero data; when undefined
// invalid lanes hold their last value and consumers must qualify with out_valid.
//
// state       | meaning
// FEED_IDLE   | waiting for start
// FEED_ISSUE  | one IBUF read per ready cycle until every row has been issued
// FEED_DRAIN  | reads done, waiting for the final row to leave lane ARRAY_N-1
// FEED_DONE   | one-cycle done pulse, then back to idle
module ibuf_skew_feeder
    import sa_pkg::*;
#(
    parameter int ARRAY_N         = SA_ARRAY_N,
    parameter int ACT_WIDTH       = SA_ACT_WIDTH,
    parameter int IBUF_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [IBUF_ADDR_WIDTH-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]           num_rows,
    input  logic                           array_ready,
    output logic                           ibuf_read_req,
    output logic [IBUF_ADDR_WIDTH-1:0]     ibuf_read_addr,
    input  logic [ARRAY_N*ACT_WIDTH-1:0]   ibuf_read_data,
    output logic [ARRAY_N*ACT_WIDTH-1:0]   out_data,
    output logic [ARRAY_N-1:0]             out_valid,
    output logic [ARRAY_N-1:0]             out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int ROW_W  = ARRAY_N * ACT_WIDTH;
    localparam int LANE_W = ACT_WIDTH + SA_LANE_TAG_WIDTH;

    feed_state_t                state_q, state_d;
    logic [IBUF_ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]       rows_q;
    logic [LEN_WIDTH-1:0]       row_q;

    logic                       issue;
    logic                       issue_last;
    logic                       start_ok;
    logic                       final_beat;

    // Read in flight: its data shows up on ibuf_read_data this cycle
    logic                       rd_pend_q;
    logic                       rd_last_q;

    // One-entry parking spot for data that lands while the array is stalled
    logic                       hold_v_q;
    logic                       hold_last_q;
    logic [ROW_W-1:0]           hold_data_q;

    // Capture register: stage 0 of every lane
    logic                       cap_v_q;
    logic                       cap_last_q;
    logic [ROW_W-1:0]           cap_data_q;

    logic [ARRAY_N-1:0]         lane_v;
    logic [ARRAY_N-1:0]         lane_l;
    logic [ROW_W-1:0]           lane_d;

    assign start_ok       = start && (state_q == FEED_IDLE);
    assign issue          = (state_q == FEED_ISSUE) && array_ready;
    assign issue_last     = issue && (row_q == rows_q - LEN_WIDTH'(1));
    assign final_beat     = lane_v[ARRAY_N-1] && lane_l[ARRAY_N-1] && array_ready;

    assign ibuf_read_req  = issue;
    assign ibuf_read_addr = base_q + IBUF_ADDR_WIDTH'(row_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FEED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            FEED_IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? FEED_DONE : FEED_ISSUE;
                end
            end
            FEED_ISSUE: begin
                busy = 1'b1;
                if (issue_last) begin
                    state_d = FEED_DRAIN;
                end
            end
            FEED_DRAIN: begin
                busy = 1'b1;
                if (final_beat) begin
                    state_d = FEED_DONE;
                end
            end
            FEED_DONE: begin
                done    = 1'b1;
                state_d = FEED_IDLE;
            end
            default: begin
                state_d = FEED_IDLE;
            end
        endcase
    end

    // Pass parameters latched on an accepted start; row counter advances per issued read
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            rows_q <= '0;
            row_q  <= '0;
        end else if (start_ok) begin
            base_q <= base_addr;
            rows_q <= num_rows;
            row_q  <= '0;
        end else if (issue) begin
            row_q  <= row_q + LEN_WIDTH'(1);
        end
    end

    // Track the read issued last cycle so its data is picked up on arrival
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_pend_q <= issue;
            rd_last_q <= issue_last;
        end
    end

    // Capture/hold: stalled arrivals park in the hold register and are consumed first
    // on release. Capture data is kept on bubbles so invalid lanes keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v_q    <= 1'b0;
            hold_last_q <= 1'b0;
            hold_data_q <= '0;
            cap_v_q     <= 1'b0;
            cap_last_q  <= 1'b0;
            cap_data_q  <= '0;
        end else if (array_ready) begin
            if (hold_v_q) begin
                cap_v_q    <= 1'b1;
                cap_last_q <= hold_last_q;
                cap_data_q <= hold_data_q;
                hold_v_q   <= 1'b0;
            end else if (rd_pend_q) begin
                cap_v_q    <= 1'b1;
                cap_last_q <= rd_last_q;
                cap_data_q <= ibuf_read_data;
            end else begin
                cap_v_q    <= 1'b0;
                cap_last_q <= 1'b0;
            end
        end else if (rd_pend_q) begin
            hold_v_q    <= 1'b1;
            hold_last_q <= rd_last_q;
            hold_data_q <= ibuf_read_data;
        end
    end

    generate
        for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
            logic [LANE_W-1:0] dly_in;
            logic [LANE_W-1:0] dly_out;

            assign dly_in = {cap_last_q, cap_v_q,
                             cap_data_q[lane_lsb(n, ACT_WIDTH) +: ACT_WIDTH]};

            skew_delay_line #(
                .WIDTH (LANE_W),
                .DEPTH (n)
            ) u_skew (
                .clk   (clk),
                .reset (reset),
                .en    (array_ready),
                .din   (dly_in),
                .dout  (dly_out)
            );

            assign lane_l[n] = dly_out[LANE_W-1];
            assign lane_v[n] = dly_out[LANE_W-2];
            assign lane_d[lane_lsb(n, ACT_WIDTH) +: ACT_WIDTH] = dly_out[ACT_WIDTH-1:0];

`ifdef FEEDER_ZERO_FILL_EN
            assign out_data[lane_lsb(n, ACT_WIDTH) +: ACT_WIDTH] =
                lane_v[n] ? lane_d[lane_lsb(n, ACT_WIDTH) +: ACT_WIDTH] : '0;
`else
            assign out_data[lane_lsb(n, ACT_WIDTH) +: ACT_WIDTH] =
                lane_d[lane_lsb(n, ACT_WIDTH) +: ACT_WIDTH];
`endif
        end
    endgenerate

    assign out_valid = lane_v;
    assign out_last  = lane_l;

endmodule

// File: tb/tb_ibuf_skew_feeder.sv
// tb_ibuf_skew_feeder: scoreboard bench for ibuf_skew_feeder. Stimulus pushes the
// expected reads, lane beats (with their cycle) and done cycle; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_ibuf_skew_feeder;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int NO_CUT = 1 << 30;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            array_ready = 1'b1;
    logic [AW-1:0]   base_addr = '0;
    logic [LW-1:0]   num_rows = '0;
    logic            ibuf_read_req;
    logic [AW-1:0]   ibuf_read_addr;
    logic [N*W-1:0]  ibuf_read_data = '0;
    logic [N*W-1:0]  out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_last;
    logic            busy;
    logic            done;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed { logic [W-1:0] data; logic last; int cyc; } beat_t;
    typedef struct packed { logic [AW-1:0] addr; int cyc; } rd_t;

    beat_t       lane_q [N][$];
    rd_t         rd_q [$];
    int          done_q [$];
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [W-1:0] lane_last [N];

    ibuf_skew_feeder #(
        .ARRAY_N(N), .ACT_WIDTH(W), .IBUF_ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_rows       (num_rows),
        .array_ready    (array_ready),
        .ibuf_read_req  (ibuf_read_req),
        .ibuf_read_addr (ibuf_read_addr),
        .ibuf_read_data (ibuf_read_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fdat(input logic [AW-1:0] a, input int n);
        return {a[11:0], n[3:0]};
    endfunction

    // IBUF model: 1-cycle read latency, contents derived from the address
    always @(posedge clk) begin
        if (ibuf_read_req) begin
            for (int n = 0; n < N; n++) ibuf_read_data[n*W +: W] <= fdat(ibuf_read_addr, n);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic note_fail(input string msg);
        n_checks++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    function automatic int adj(input int c, input int st_at, input int st_len);
        return (st_len > 0 && c >= st_at) ? c + st_len : c;
    endfunction

    // Expected schedule: row r issued at T0+r, lane n beat at T0+r+2+n, shifted by
    // the stall length when at/after the stall point; only events before cutoff count.
    task automatic push_pass(input logic [AW-1:0] base, input int rows, input int s,
                             input int st_at, input int st_len, input int cutoff);
        int t0, c, dn;
        logic [AW-1:0] a;
        rd_t rr;
        beat_t bb;
        t0 = s + 1;
        busy_lo = t0;
        if (rows == 0) begin
            dn = s + 1;
        end else begin
            for (int r = 0; r < rows; r++) begin
                a = base + AW'(r);
                c = adj(t0 + r, st_at, st_len);
                if (c < cutoff) begin
                    rr.addr = a; rr.cyc = c; rd_q.push_back(rr);
                end
                for (int n = 0; n < N; n++) begin
                    c = adj(t0 + r + 2 + n, st_at, st_len);
                    if (c < cutoff) begin
                        bb.data = fdat(a, n); bb.last = (r == rows - 1); bb.cyc = c;
                        lane_q[n].push_back(bb);
                    end
                end
            end
            dn = adj(t0 + rows - 1 + 2 + N - 1, st_at, st_len) + 1;
        end
        busy_hi = (dn - 1 < cutoff - 1) ? dn - 1 : cutoff - 1;
        if (dn < cutoff) done_q.push_back(dn);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic kick(input logic [AW-1:0] base, input int rows, input int st_rel,
                        input int st_len, input int cut_rel, output int s);
        tick();
        s = cyc;
        push_pass(base, rows, s, s + st_rel, st_len, (cut_rel < 0) ? NO_CUT : s + cut_rel);
        start = 1'b1; base_addr = base; num_rows = LW'(rows);
        tick();
        start = 1'b0;
    endtask

    // Monitor: reads, lane beats, bubbles, busy and done
    always @(negedge clk) begin
        rd_t rr;
        beat_t bb;
        if (!reset) begin
            chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            if (ibuf_read_req) begin
                if (rd_q.size() == 0) note_fail($sformatf("rd_unexpected addr %0h", ibuf_read_addr));
                else begin
                    rr = rd_q.pop_front();
                    chk("rd_addr", ibuf_read_addr, rr.addr);
                    chk("rd_cycle", cyc, rr.cyc);
                end
            end
            for (int n = 0; n < N; n++) begin
                if (out_valid[n]) begin
                    if (array_ready) begin
                        if (lane_q[n].size() == 0) note_fail($sformatf("beat_unexpected lane %0d", n));
                        else begin
                            bb = lane_q[n].pop_front();
                            chk($sformatf("lane%0d_data", n), out_data[n*W +: W], bb.data);
                            chk($sformatf("lane%0d_last", n), out_last[n], bb.last);
                            chk($sformatf("lane%0d_cycle", n), cyc, bb.cyc);
                            lane_last[n] = bb.data;
                        end
                    end
                end else begin
`ifdef FEEDER_ZERO_FILL_EN
                    chk($sformatf("lane%0d_bubble_zero", n), out_data[n*W +: W], '0);
`else
                    chk($sformatf("lane%0d_bubble_hold", n), out_data[n*W +: W], lane_last[n]);
`endif
                end
            end
            if (done) begin
                if (done_q.size() == 0) note_fail("done_unexpected");
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin
        int s;
        int left;
        for (int n = 0; n < N; n++) lane_last[n] = '0;

        // Reset state
        @(posedge clk); @(negedge clk);
        chk("rst_valid", out_valid, '0);
        chk("rst_last", out_last, '0);
        chk("rst_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", ibuf_read_req, 1'b0);
        chk("rst_addr", ibuf_read_addr, '0);
        tick(); reset = 1'b0;
        repeat (2) tick();

        // base 0x10, 3 rows, no stall
        kick(16'h0010, 3, 0, 0, -1, s);
        repeat (12) tick();
        chk("p1_done_seen", done_q.size(), 0);

        // zero rows: done only, no reads, busy never high
        kick(16'h0055, 0, 0, 0, -1, s);
        repeat (3) tick();
        chk("p2_done_seen", done_q.size(), 0);

        // 4 rows, array_ready low for 3 cycles right after the 2nd read
        kick(16'h0200, 4, 3, 3, -1, s);
        tick(); tick(); array_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 4'b0001);
            chk("stall_lane0", out_data[W-1:0], fdat(16'h0200, 0));
            chk("stall_req", ibuf_read_req, 1'b0);
            if (k < 2) tick();
        end
        tick(); array_ready = 1'b1;
        repeat (10) tick();
        chk("p3_done_seen", done_q.size(), 0);

        // address wrap
        kick(16'hFFFE, 4, 0, 0, -1, s);
        repeat (14) tick();
        chk("p4_done_seen", done_q.size(), 0);

        // start while busy is ignored
        kick(16'h0300, 3, 0, 0, -1, s);
        tick(); start = 1'b1; base_addr = 16'h0777; num_rows = 16'd5;
        tick(); start = 1'b0;
        repeat (12) tick();
        chk("p5_done_seen", done_q.size(), 0);

        // reset in the middle of ISSUE
        kick(16'h0400, 8, 0, 0, 4, s);
        tick(); tick();
        tick(); reset = 1'b1;
        for (int n = 0; n < N; n++) lane_last[n] = '0;
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (15) tick();

        // clean pass after the abort
        kick(16'h0500, 2, 0, 0, -1, s);
        repeat (12) tick();
        chk("p7_done_seen", done_q.size(), 0);

        left = rd_q.size();
        for (int n = 0; n < N; n++) left += lane_q[n].size();
        chk("queues_drained", left, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
